eth_pkt_gen: RTL
================

Name: eth_pkt_gen

Overview:
Parametrised Ethernet frame generator driving the byte-stream TX interface of eth_tx (tx_vld/tx_dat/tx_sof/tx_eof/tx_err/tx_ack) in the clk_mac domain.
Builds frames from a header (dst, src, ethertype, sequence number) and a selectable payload pattern (zero, incrementing, PRBS-8).
Sends a programmed number of frames, or runs continuously, with a fixed inter-frame gap.
Used for loopback bring-up on the board and as reusable stimulus for eth_tx/eth_rx benches.

Parameters:
MIN_LEN, 60, minimum frame length in bytes (excluding preamble/FCS); shorter cfg_len clamped up
MAX_LEN, 1514, maximum frame length; longer cfg_len clamped down
LEN_W, 11, width of cfg_len and internal byte counter
IFG_CYCLES, 12, idle clk_mac cycles with tx_vld=0 between frames
ETHERTYPE, 16'h88B5, value placed in bytes 12-13

Ports:
clk_mac  in  1  MAC clock (50 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_* and begins a run; ignored while busy
stop  in  1  pulse; ends run after current frame completes
cfg_len  in  LEN_W  frame length in bytes
cfg_count  in  16  frames per run; 0 = continuous until stop
cfg_mode  in  2  payload: 0 zero, 1 incrementing, 2 PRBS-8, 3 treated as 0
cfg_dst  in  48  destination MAC, byte 0 = bits [47:40]
cfg_src  in  48  source MAC, same ordering
tx_vld  out  1  byte valid
tx_dat  out  8  byte data
tx_sof  out  1  first byte of frame
tx_eof  out  1  last byte of frame
tx_err  out  1  frame error flag toward eth_tx
tx_ack  in  1  byte accepted by eth_tx
busy  out  1  run in progress
frames_sent  out  16  frames completed in current/last run
done  out  1  one-cycle pulse when run ends

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FSM IDLE, stop latch cleared. Reset mid-frame abandons the frame immediately; no eof is generated.
- Transfer: a byte is transferred when tx_vld && tx_ack. While tx_vld=1 && tx_ack=0, tx_dat/tx_sof/tx_eof/tx_err hold stable. tx_vld is never dropped inside a frame.
- Length: L = clamp(cfg_len, MIN_LEN, MAX_LEN). L and all cfg_* are latched on start; later changes have no effect until the next start.
- Frame bytes:
  - 0-5: dst
  - 6-11: src
  - 12-13: ETHERTYPE, MSB first
  - 14-15: sequence number (0-based frame index within the run, 16-bit, wraps), MSB first
  - 16..L-1: payload
- Payload modes:
  - mode 0: 8'h00.
  - mode 1: byte index[7:0], so byte 16 = 8'h10, wraps after 8'hFF.
  - mode 2: Fibonacci LFSR, shift left, feedback bit = b7^b5^b4^b3. Seeded 8'hFF at each frame start; byte 16 = seed; the LFSR advances on each accepted payload byte.
- tx_sof is 1 on byte 0 only; tx_eof is 1 on byte L-1 only.
- FSM:
  - IDLE -> HDR on start: busy=1, frames_sent=0, tx_vld=1 from the next cycle.
  - HDR -> PAYLOAD after byte 15 is accepted.
  - On acceptance of the eof byte: frames_sent++. If (cfg_count!=0 && frames_sent+1==cfg_count) or stop latched -> IDLE with done=1 for one cycle and busy=0. Otherwise -> GAP.
  - GAP: tx_vld=0 for exactly IFG_CYCLES cycles, then HDR.
- stop: latched whenever busy. Never truncates a frame. Stop during GAP ends the run at the end of GAP with done, and no new frame starts.
- start and stop in the same cycle while IDLE: start wins; stop is ignored.
- Latency: start in cycle N gives tx_vld=1 with byte 0 in cycle N+1.
- frames_sent holds its value after the run ends; it is cleared only by the next start or by reset.

Optional Feature:
ERR_INJ_EN:
- Defined: adds input cfg_err_every [7:0], latched on start. If nonzero, tx_err=1 on the eof byte of every frame whose 1-based index is a multiple of cfg_err_every; tx_err=0 elsewhere.
- Undefined: port absent; tx_err constant 0.

Test Plan:
1. cfg_len=64, count=1, mode 0, dst=FF..FF, src=00..00, tx_ack=1 -> 64 accepted bytes; sof on byte 0, eof on byte 63; bytes 12-13 = 88 B5, 14-15 = 00 00, payload all 00; done pulse; frames_sent=1.
2. Same config as scenario 1 with tx_ack random at 50% -> identical byte sequence; tx_dat/sof/eof stable on every tx_vld&&!tx_ack cycle; tx_vld never low inside the frame.
3. cfg_len=20, count=3, mode 1 -> three frames of 60 bytes; sequence numbers 0,1,2; byte 16=10, byte 59=3B; exactly 12 cycles of tx_vld=0 between frames; frames_sent=3.
4. cfg_len=64, count=1, mode 2 -> payload bytes 16-21 = FF FE FC F8 F0 E1.
5. count=0, stop pulsed mid-frame 2 -> frame 2 completes with eof; no third sof; done pulse; frames_sent=2; busy=0.
6. rst_n low at byte 30 of a frame -> all outputs 0 immediately; after release, tx_vld stays 0 until the next start; the next run's sequence number starts at 0.

Source files
------------

// File: rtl/eth_pkt_gen_if.sv
// Byte-stream TX handshake between eth_pkt_gen (master) and eth_tx (slave).
// A byte moves on tx_vld && tx_ack; while tx_vld && !tx_ack the master holds dat/sof/eof/err.
interface eth_pkt_gen_if;
    logic       tx_vld;
    logic [7:0] tx_dat;
    logic       tx_sof;
    logic       tx_eof;
    logic       tx_err;
    logic       tx_ack;

    modport master (output tx_vld, tx_dat, tx_sof, tx_eof, tx_err, input tx_ack);
    modport slave  (input tx_vld, tx_dat, tx_sof, tx_eof, tx_err, output tx_ack);
endinterface

// File: rtl/eth_pkt_gen.sv
// Ethernet frame generator: header + zero/incrementing/PRBS-8 payload, fixed IFG.
// Optional build macro ERR_INJ_EN adds cfg_err_every and periodic tx_err on eof bytes.
module eth_pkt_gen #(
    parameter int          MIN_LEN    = 60,
    parameter int          MAX_LEN    = 1514,
    parameter int          LEN_W      = 11,
    parameter int          IFG_CYCLES = 12,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
    input  logic             clk_mac,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [15:0]      cfg_count,
    input  logic [1:0]       cfg_mode,
    input  logic [47:0]      cfg_dst,
    input  logic [47:0]      cfg_src,
`ifdef ERR_INJ_EN
    input  logic [7:0]       cfg_err_every,
`endif
    eth_pkt_gen_if.master    tx,
    output logic             busy,
    output logic [15:0]      frames_sent,
    output logic             done,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAYLOAD = 2'd2, GAP = 2'd3} state_t;
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);

    state_t           state;
    logic [LEN_W-1:0] len_q, len_c, last_idx, byte_idx, nidx;
    logic [15:0]      count_q;
    logic [1:0]       mode_q;
    logic [47:0]      dst_q, src_q;
    logic [7:0]       lfsr, nbyte;
    logic [GAP_W-1:0] gap_cnt;
    logic             stop_q, err_hit, run_end;
    logic [127:0]     hdr_sh;

    assign state_dbg = state;
    assign last_idx  = len_q - LEN_W'(1);
    assign run_end   = ((count_q != 16'd0) && (frames_sent + 16'd1 == count_q)) || stop_q || stop;

    always_comb begin
        len_c = cfg_len;
        if (cfg_len < LEN_W'(MIN_LEN))      len_c = LEN_W'(MIN_LEN);
        else if (cfg_len > LEN_W'(MAX_LEN)) len_c = LEN_W'(MAX_LEN);
    end

    // Byte that follows the one currently on the bus; the sequence number is the
    // running frame count, which already points at the frame being sent.
    always_comb begin
        nidx   = byte_idx + LEN_W'(1);
        hdr_sh = {dst_q, src_q, ETHERTYPE, frames_sent} << {nidx[3:0], 3'b000};
        nbyte  = 8'h00;
        if (nidx < LEN_W'(16)) nbyte = hdr_sh[127:120];
        else if (mode_q == 2'd1) nbyte = nidx[7:0];
        else if (mode_q == 2'd2) nbyte = lfsr;
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

`ifdef ERR_INJ_EN
    logic [7:0] err_every_q, err_cnt;
    // err_cnt holds (frame index - 1) mod cfg_err_every for the frame in flight.
    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            err_every_q <= 8'd0;
            err_cnt     <= 8'd0;
        end else if (state == IDLE && start) begin
            err_every_q <= cfg_err_every;
            err_cnt     <= 8'd0;
        end else if (tx.tx_vld && tx.tx_ack && tx.tx_eof) begin
            err_cnt <= err_hit ? 8'd0 : err_cnt + 8'd1;
        end
    end
    assign err_hit = (err_every_q != 8'd0) && (err_cnt == err_every_q - 8'd1);
`else
    assign err_hit = 1'b0;
`endif

    always_ff @(posedge clk_mac or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            mode_q      <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            byte_idx    <= '0;
            lfsr        <= 8'hFF;
            gap_cnt     <= '0;
            stop_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frames_sent <= '0;
            tx.tx_vld   <= 1'b0;
            tx.tx_dat   <= 8'h00;
            tx.tx_sof   <= 1'b0;
            tx.tx_eof   <= 1'b0;
            tx.tx_err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy && stop) stop_q <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    len_q       <= len_c;
                    count_q     <= cfg_count;
                    mode_q      <= cfg_mode;
                    dst_q       <= cfg_dst;
                    src_q       <= cfg_src;
                    busy        <= 1'b1;
                    frames_sent <= '0;
                    stop_q      <= 1'b0;
                    byte_idx    <= '0;
                    lfsr        <= 8'hFF;
                    tx.tx_vld   <= 1'b1;
                    tx.tx_dat   <= cfg_dst[47:40];
                    tx.tx_sof   <= 1'b1;
                    tx.tx_eof   <= 1'b0;
                    tx.tx_err   <= 1'b0;
                    state       <= HDR;
                end
                HDR, PAYLOAD: if (tx.tx_ack) begin
                    if (tx.tx_eof) begin
                        frames_sent <= frames_sent + 16'd1;
                        tx.tx_vld   <= 1'b0;
                        tx.tx_dat   <= 8'h00;
                        tx.tx_sof   <= 1'b0;
                        tx.tx_eof   <= 1'b0;
                        tx.tx_err   <= 1'b0;
                        gap_cnt     <= '0;
                        if (run_end) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            stop_q <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        byte_idx  <= nidx;
                        tx.tx_dat <= nbyte;
                        tx.tx_sof <= 1'b0;
                        tx.tx_eof <= (nidx == last_idx);
                        tx.tx_err <= (nidx == last_idx) && err_hit;
                        if (nidx >= LEN_W'(16) && mode_q == 2'd2) lfsr <= lfsr_step(lfsr);
                        if (nidx == LEN_W'(16)) state <= PAYLOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) begin
                        if (stop_q || stop) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            stop_q <= 1'b0;
                        end else begin
                            byte_idx  <= '0;
                            lfsr      <= 8'hFF;
                            tx.tx_vld <= 1'b1;
                            tx.tx_dat <= dst_q[47:40];
                            tx.tx_sof <= 1'b1;
                            state     <= HDR;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
